// File: rtl/lvds_tx_word_fifo_if.sv
// rtl/lvds_tx_word_fifo_if.sv - payload in / head word out handshake bundle for lvds_tx_word_fifo
//
// Signals:
//   in_data     31   user payload offered to the FIFO
//   in_valid    1    user offers in_data
//   in_ready    1    FIFO can accept a word (registered in the FIFO)
//   enq_tx      32   head word {1'b1, payload}, 32'h0 when empty
//   RDY_enq_tx  1    head word valid
//   EN_enq_tx   1    link FSM dequeue strobe
// Modports:
//   master  user logic + link FSM side
//   slave   FIFO side
interface lvds_tx_word_fifo_if;
  logic [30:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] enq_tx;
  logic        RDY_enq_tx;
  logic        EN_enq_tx;

  modport master (
    output in_data, in_valid, EN_enq_tx,
    input  in_ready, enq_tx, RDY_enq_tx
  );

  modport slave (
    input  in_data, in_valid, EN_enq_tx,
    output in_ready, enq_tx, RDY_enq_tx
  );
endinterface

// File: rtl/lvds_tx_word_fifo.sv
// rtl/lvds_tx_word_fifo.sv - tags 31-bit payloads and buffers them in a FWFT FIFO for the LVDS TX link FSM
//
// Ports:
//   tx_inclock     clock, all logic on posedge
//   reset_n        synchronous active-low reset
//   bus            slave side of lvds_tx_word_fifo_if (payload in, head word out)
//   level          current word count, 0..2**DEPTH_LOG2
//   almost_full    level >= AFULL_THRESH (registered)
//   err_underflow  sticky: dequeue strobe seen while empty
//   err_clear      clears err_underflow, wins over a same-cycle set
module lvds_tx_word_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  tx_inclock,
  input  logic                  reset_n,
  lvds_tx_word_fifo_if.slave    bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  err_underflow,
  input  logic                  err_clear
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AFULL_L = AFULL_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  in_ready_q;
  logic                  not_empty;
  logic                  push;
  logic                  pop;

  // Empty/full are decided by level alone; the pointers are equal in both cases.
  assign not_empty = (level != '0);
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = bus.EN_enq_tx && not_empty;

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end
  end

  // Storage is not reset; stale entries are hidden by the not_empty gate.
  always_ff @(posedge tx_inclock) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= {1'b1, bus.in_data};
    end
  end

  always_ff @(posedge tx_inclock) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      in_ready_q    <= 1'b1;
      almost_full   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level       <= level_next;
      in_ready_q  <= (level_next < DEPTH_L);
      almost_full <= (level_next >= AFULL_L);
      if (err_clear) begin
        err_underflow <= 1'b0;
      end else if (bus.EN_enq_tx && !not_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Head word is a direct read of storage, so nothing from in_data reaches it in the same cycle.
  assign bus.enq_tx     = not_empty ? mem[rd_ptr] : 32'h0;
  assign bus.RDY_enq_tx = not_empty;
  assign bus.in_ready   = in_ready_q;

endmodule

// File: tb/tb_lvds_tx_word_fifo.sv
// tb/tb_lvds_tx_word_fifo.sv - scoreboard bench for lvds_tx_word_fifo
module tb_lvds_tx_word_fifo;

  logic       tx_inclock = 1'b0;
  logic       reset_n;
  logic       err_clear;
  logic [4:0] level;
  logic       almost_full;
  logic       err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];

  lvds_tx_word_fifo_if bus ();

  lvds_tx_word_fifo #(.DEPTH_LOG2(4), .AFULL_THRESH(12)) dut (
    .tx_inclock    (tx_inclock),
    .reset_n       (reset_n),
    .bus           (bus),
    .level         (level),
    .almost_full   (almost_full),
    .err_underflow (err_underflow),
    .err_clear     (err_clear)
  );

  always #5 tx_inclock = ~tx_inclock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_inclock);
    #1;
  endtask

  // Offer one payload; hold until accepted, then record the tagged word expected at the head.
  task automatic push_word(input logic [30:0] d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'h0, bus.in_ready}, 32'h1);
    exp_q.push_back({1'b1, d});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_word();
    bus.EN_enq_tx = 1'b1;
    tick();
    bus.EN_enq_tx = 1'b0;
  endtask

  // Monitor: every dequeue the DUT performs must present the oldest expected word.
  always @(negedge tx_inclock) begin
    if (reset_n === 1'b1 && bus.EN_enq_tx === 1'b1 && bus.RDY_enq_tx === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("head_unexpected", bus.enq_tx, 32'hxxxx_xxxx);
      end else begin
        check("head_word", bus.enq_tx, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    err_clear     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.EN_enq_tx = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    check("rst_level", {27'h0, level}, 32'd0);
    check("rst_rdy", {31'h0, bus.RDY_enq_tx}, 32'd0);
    check("rst_enq", bus.enq_tx, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("rst_afull", {31'h0, almost_full}, 32'd0);
    check("rst_err", {31'h0, err_underflow}, 32'd0);

    // single word fall-through
    push_word(31'h0000_1234);
    check("t1_rdy", {31'h0, bus.RDY_enq_tx}, 32'd1);
    check("t1_enq", bus.enq_tx, 32'h8000_1234);
    check("t1_level", {27'h0, level}, 32'd1);
    pop_word();
    check("t1_empty", {27'h0, level}, 32'd0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      push_word(31'(i));
      check("t2_level", {27'h0, level}, 32'(i + 1));
      check("t2_afull", {31'h0, almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
    end
    check("t2_in_ready_full", {31'h0, bus.in_ready}, 32'd0);
    check("t2_head", bus.enq_tx, 32'h8000_0000);
    bus.in_data  = 31'd16;
    bus.in_valid = 1'b1;
    tick();
    tick();
    tick();
    check("t2_held_level", {27'h0, level}, 32'd16);
    check("t2_held_ready", {31'h0, bus.in_ready}, 32'd0);

    // stream: one pop every 4 cycles while pushes wait on in_ready
    fork
      begin
        for (int w = 16; w < 32; w++) push_word(31'(w));
      end
      begin
        for (int k = 0; k < 16; k++) begin
          pop_word();
          check("t3_ready_after_pop", {31'h0, bus.in_ready}, 32'd1);
          tick();
          tick();
          tick();
          check("t3_level_refill", {27'h0, level}, 32'd16);
          check("t3_ready_refull", {31'h0, bus.in_ready}, 32'd0);
        end
      end
    join
    for (int k = 0; k < 16; k++) begin
      pop_word();
      tick();
      tick();
      tick();
    end
    check("t3_drained_level", {27'h0, level}, 32'd0);
    check("t3_drained_rdy", {31'h0, bus.RDY_enq_tx}, 32'd0);
    check("t3_drained_enq", bus.enq_tx, 32'h0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // simultaneous push and pop at level 1
    push_word(31'h0000_000A);
    bus.in_data   = 31'h5;
    bus.in_valid  = 1'b1;
    bus.EN_enq_tx = 1'b1;
    exp_q.push_back(32'h8000_0005);
    tick();
    bus.in_valid  = 1'b0;
    bus.EN_enq_tx = 1'b0;
    check("t4_enq", bus.enq_tx, 32'h8000_0005);
    check("t4_level", {27'h0, level}, 32'd1);
    pop_word();

    // underflow flag
    bus.EN_enq_tx = 1'b1;
    tick();
    bus.EN_enq_tx = 1'b0;
    check("t5_err_set", {31'h0, err_underflow}, 32'd1);
    check("t5_rdy", {31'h0, bus.RDY_enq_tx}, 32'd0);
    check("t5_enq", bus.enq_tx, 32'h0);
    check("t5_level", {27'h0, level}, 32'd0);
    tick();
    tick();
    check("t5_err_sticky", {31'h0, err_underflow}, 32'd1);
    err_clear     = 1'b1;
    bus.EN_enq_tx = 1'b1;
    tick();
    err_clear     = 1'b0;
    bus.EN_enq_tx = 1'b0;
    check("t5_clear_priority", {31'h0, err_underflow}, 32'd0);
    tick();
    check("t5_err_cleared", {31'h0, err_underflow}, 32'd0);

    // reset with 7 words buffered
    for (int i = 0; i < 7; i++) push_word(31'h0000_0070 + 31'(i));
    check("t6_level7", {27'h0, level}, 32'd7);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    check("t6_level", {27'h0, level}, 32'd0);
    check("t6_rdy", {31'h0, bus.RDY_enq_tx}, 32'd0);
    check("t6_enq", bus.enq_tx, 32'h0);
    check("t6_in_ready", {31'h0, bus.in_ready}, 32'd1);
    push_word(31'h0000_0100);
    check("t6_first_out", bus.enq_tx, 32'h8000_0100);
    pop_word();
    for (int i = 1; i < 40; i++) begin
      push_word(31'h0000_0100 + 31'(i));
      pop_word();
    end
    check("t6_wrap_level", {27'h0, level}, 32'd0);
    check("t6_wrap_queue", 32'(exp_q.size()), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
